// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: IDLE/FETCH/VALID sequencer holding PC and instruction register.
// Define IFU_RETIRE_CNT_EN to add the retire_count output (consumed-instruction counter).
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        jump,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  func,
  output logic [31:0] pc,
`ifdef IFU_RETIRE_CNT_EN
  output logic [31:0] retire_count,
`endif
  output logic [31:0] pc_plus4
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    VALID
  } state_t;

  // Low address bits are forced to zero so a misaligned RESET_PC cannot leak out.
  localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc_q;
  logic [31:0] ir;
  logic        load_ir;
  logic        consume;
  logic [31:0] jump_target;
  logic [31:0] branch_target;
  logic [31:0] pc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    load_ir     = 1'b0;
    consume     = 1'b0;
    case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          load_ir   = 1'b1;
          state_nxt = VALID;
        end
      end
      VALID: begin
        instr_valid = 1'b1;
        if (!stall) begin
          consume   = 1'b1;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign pc_plus4      = pc_q + 32'd4;
  assign jump_target   = {pc_plus4[31:28], ir[25:0], 2'b00};
  assign branch_target = pc_plus4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};

  always_comb begin
    pc_next = pc_plus4;
    if (jump)              pc_next = jump_target;
    else if (branch_taken) pc_next = branch_target;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= PC_INIT;
      ir   <= '0;
    end else begin
      if (load_ir) ir   <= imem_rdata;
      if (consume) pc_q <= pc_next;
    end
  end

`ifdef IFU_RETIRE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       retire_count <= '0;
    else if (consume) retire_count <= retire_count + 32'd1;
  end
`endif

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign instr     = ir;
  assign opcode    = ir[31:26];
  assign func      = ir[5:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: random memory latency, stalls and control flow
// checked against a PC-sequence reference model; directed scenarios run first.
module tb_instr_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] HI_PC    = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_ack, stall, jump, branch_taken, instr_valid;
  logic [31:0] imem_addr, imem_rdata, instr, pc, pc_plus4;
  logic [15:0] branch_offset;
  logic [5:0]  opcode, func;
`ifdef IFU_RETIRE_CNT_EN
  logic [31:0] retire_count, hi_retire;
`endif

  logic        hi_req, hi_ack, hi_valid;
  logic [31:0] hi_addr, hi_instr, hi_pc, hi_pc4;
  logic [5:0]  hi_opcode, hi_func;
  logic [31:0] hi_rdata = 32'h0800_0010;
  logic        hi_stall = 1'b0;
  logic        hi_jump = 1'b1;
  logic        hi_br = 1'b1;
  logic [15:0] hi_off = 16'h0004;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(RESET_PC)) u_dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall), .jump(jump),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .instr_valid(instr_valid), .instr(instr), .opcode(opcode), .func(func), .pc(pc),
`ifdef IFU_RETIRE_CNT_EN
    .retire_count(retire_count),
`endif
    .pc_plus4(pc_plus4)
  );

  instr_fetch_unit #(.RESET_PC(HI_PC)) u_hi (
    .clk(clk), .rst_n(rst_n), .imem_req(hi_req), .imem_addr(hi_addr),
    .imem_ack(hi_ack), .imem_rdata(hi_rdata), .stall(hi_stall), .jump(hi_jump),
    .branch_taken(hi_br), .branch_offset(hi_off),
    .instr_valid(hi_valid), .instr(hi_instr), .opcode(hi_opcode), .func(hi_func), .pc(hi_pc),
`ifdef IFU_RETIRE_CNT_EN
    .retire_count(hi_retire),
`endif
    .pc_plus4(hi_pc4)
  );

  assign hi_ack = hi_req;

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memory image and reference model ----------------
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] w,
                                           input bit j, input bit b, input logic [15:0] off);
    logic [31:0] seq;
    int disp;
    seq  = p + 32'd4;
    disp = int'($signed(off));
    if (j) return (seq & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
    if (b) return seq + 32'(disp * 4);
    return seq;
  endfunction

  typedef struct {
    int          stalls;
    bit          j;
    bit          b;
    logic [15:0] off;
  } step_t;

  step_t       script[$];
  logic [31:0] exp_q[$];
  logic [31:0] cur_pc;
  int          retired = 0;
  int          fixed_wait = 0;
  bit          force_ack = 1'b0;

  // ---------------- control driver: stalls and consume-time control flow ----------------
  initial begin
    bit          prev_v = 1'b0;
    int          stall_left = 0;
    step_t       st;
    logic [31:0] nxt;
    stall = 1'b0; jump = 1'b0; branch_taken = 1'b0; branch_offset = '0;
    forever begin
      @(posedge clk); #2;
      if (!rst_n) begin
        prev_v = 1'b0; stall = 1'b0; stall_left = 0;
        continue;
      end
      jump          = 1'($urandom_range(0, 1));
      branch_taken  = 1'($urandom_range(0, 1));
      branch_offset = 16'($urandom);
      if (instr_valid) begin
        if (!prev_v) begin
          if (script.size() > 0) st = script.pop_front();
          else begin
            st.stalls = int'($urandom_range(0, 2));
            st.j      = ($urandom_range(0, 3) == 0);
            st.b      = 1'($urandom_range(0, 1));
            st.off    = 16'($urandom);
          end
          stall_left = st.stalls;
        end
        if (stall_left > 0) begin
          stall = 1'b1;
          stall_left--;
          prev_v = 1'b1;
        end else begin
          stall = 1'b0; jump = st.j; branch_taken = st.b; branch_offset = st.off;
          nxt = ref_next(cur_pc, word_at(cur_pc), st.j, st.b, st.off);
          exp_q.push_back(nxt);
          cur_pc = nxt;
          retired++;
          prev_v = 1'b0;
        end
      end else begin
        stall  = 1'($urandom_range(0, 1));
        prev_v = 1'b0;
      end
    end
  end

  // ---------------- memory responder with latency and stray acks ----------------
  initial begin
    bit in_req = 1'b0;
    int wcnt = 0;
    int wlim = 0;
    imem_ack = 1'b0; imem_rdata = '0;
    forever begin
      @(posedge clk); #2;
      if (force_ack) begin
        imem_ack = 1'b1; imem_rdata = $urandom;
        in_req = 1'b0;
      end else if (rst_n && imem_req) begin
        if (!in_req) begin
          in_req = 1'b1; wcnt = 0;
          wlim = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
        end
        if (wcnt == wlim) begin
          imem_ack = 1'b1; imem_rdata = word_at(imem_addr);
        end else begin
          imem_ack = 1'b0; imem_rdata = $urandom; wcnt++;
        end
      end else begin
        in_req = 1'b0;
        imem_ack = ($urandom_range(0, 3) == 0);
        imem_rdata = $urandom;
      end
    end
  end

  // ---------------- monitor: pops expectations when the DUT presents them ----------------
  initial begin
    bit          pv = 1'b0, pr = 1'b0, pa = 1'b0, ps = 1'b0;
    logic [31:0] paddr = '0, held_pc = '0, held_w = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0; pr = 1'b0; pa = 1'b0; ps = 1'b0;
        continue;
      end
      if (pr && pa) check("valid_one_cycle_after_ack", 32'(instr_valid), 32'd1);
      if (pr && !pa && imem_req) check("addr_stable_while_waiting", imem_addr, paddr);
      if (pv && !ps) begin
        check("req_after_consume", 32'(imem_req), 32'd1);
        check("valid_drops_after_consume", 32'(instr_valid), 32'd0);
      end
      if (imem_req && imem_ack) begin
        if (exp_q.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL fetch_addr: fetch of %h with no expected address", imem_addr);
        end else check("fetch_addr", imem_addr, exp_q[0]);
      end
      if (instr_valid && !pv) begin
        if (exp_q.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL instr_pc: valid instruction at %h with none expected", pc);
        end else begin
          held_pc = exp_q.pop_front();
          held_w  = word_at(held_pc);
          check("instr_pc", pc, held_pc);
          check("instr_word", instr, held_w);
          check("opcode", 32'(opcode), 32'(held_w[31:26]));
          check("func", 32'(func), 32'(held_w[5:0]));
          check("pc_plus4", pc_plus4, held_pc + 32'd4);
        end
      end else if (instr_valid) begin
        check("hold_pc_in_stall", pc, held_pc);
        check("hold_instr_in_stall", instr, held_w);
      end
      pv = instr_valid; ps = stall; pr = imem_req; pa = imem_ack; paddr = imem_addr;
    end
  end

  task automatic wait_retired(input int n, input int budget, input string name);
    int cyc = 0;
    while (retired < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (retired < n) begin
      compared++; mismatched++;
      $display("FAIL %s: timeout, retired %0d, required %0d", name, retired, n);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_q.push_back(RESET_PC);
    cur_pc  = RESET_PC;
    retired = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] hi_q[$];
    bit          seen;

    mem[32'h0000_0000] = 32'h2008_0005;
    mem[32'h0000_0008] = 32'h0800_0010;
    mem[32'h0000_0044] = 32'h0800_0040;
    mem[32'h0000_00F4] = 32'h0800_0040;
    mem[32'h0000_0110] = 32'h0800_0000;
    script.push_back('{0, 1'b0, 1'b0, 16'h0000});  // 0 -> 4
    script.push_back('{0, 1'b0, 1'b0, 16'h0000});  // 4 -> 8
    script.push_back('{0, 1'b1, 1'b0, 16'h0000});  // 8 -> 0x40
    script.push_back('{5, 1'b0, 1'b0, 16'h0000});  // 0x40 held 5 cycles -> 0x44
    script.push_back('{0, 1'b1, 1'b0, 16'h0000});  // 0x44 -> 0x100
    script.push_back('{0, 1'b0, 1'b1, 16'hFFFC});  // 0x100 -> 0xF4
    script.push_back('{1, 1'b1, 1'b0, 16'h0000});  // 0xF4 -> 0x100
    script.push_back('{0, 1'b0, 1'b1, 16'h0003});  // 0x100 -> 0x110
    script.push_back('{2, 1'b1, 1'b1, 16'h1234});  // jump beats branch -> 0
    script.push_back('{0, 1'b0, 1'b1, 16'hFFFE});  // 0 -> 0xFFFF_FFFC
    script.push_back('{0, 1'b0, 1'b0, 16'h0000});  // wraps to 0

    repeat (3) @(negedge clk);
    #1 check("reset_valid", 32'(instr_valid), 32'd0);
    check("reset_req", 32'(imem_req), 32'd0);
    check("reset_pc", pc, RESET_PC);
    check("reset_ir", instr, 32'd0);
`ifdef IFU_RETIRE_CNT_EN
    check("reset_retire", retire_count, 32'd0);
`endif
    @(negedge clk);
    model_reset();
    fixed_wait = 0;
    rst_n = 1'b1;
    #1 check("no_req_before_edge", 32'(imem_req), 32'd0);

    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 0) begin
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", imem_addr, RESET_PC);
      end
      if (hi_req && hi_ack && hi_q.size() < 3) hi_q.push_back(hi_addr);
      if (retired >= 3) fixed_wait = 3;
    end
    check("hi_fetch_count", 32'(hi_q.size()), 32'd3);
    if (hi_q.size() == 3) begin
      check("hi_fetch0", hi_q[0], HI_PC);
      check("hi_jump_over_branch", hi_q[1], 32'h3000_0040);
      check("hi_jump_repeat", hi_q[2], 32'h3000_0040);
    end

    wait_retired(5, 500, "directed_wait3");
    fixed_wait = -1;
    wait_retired(11, 1000, "directed_script");
    wait_retired(211, 6000, "random_run");

    // reset in the middle of a long fetch, ack asserted while reset is low
    fixed_wait = 50;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = imem_req;
    end
    if (!seen) begin
      compared++; mismatched++;
      $display("FAIL reset_mid_fetch: no request seen, got req=%b, required 1", imem_req);
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    force_ack = 1'b1;
    #1 check("async_reset_req", 32'(imem_req), 32'd0);
    check("async_reset_valid", 32'(instr_valid), 32'd0);
    check("async_reset_pc", pc, RESET_PC);
    check("async_reset_ir", instr, 32'd0);
`ifdef IFU_RETIRE_CNT_EN
    check("async_reset_retire", retire_count, 32'd0);
`endif
    repeat (2) @(posedge clk);
    #3 check("valid_low_with_ack_in_reset", 32'(instr_valid), 32'd0);
    @(negedge clk);
    model_reset();
    fixed_wait = 0;
    force_ack = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("refetch_valid_low", 32'(instr_valid), 32'd0);
    check("refetch_req", 32'(imem_req), 32'd1);
    check("refetch_addr", imem_addr, RESET_PC);
    fixed_wait = -1;
    wait_retired(20, 1000, "post_reset_run");

`ifdef IFU_RETIRE_CNT_EN
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = imem_req;
    end
    check("retire_count", retire_count, 32'(retired));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
